conv2d_stream: RTL and testbench

//  Streaming KxK 2-D convolution engine with bias and optional ReLU. Takes one pixel per

---
 rtl/conv2d_stream.sv | 115 +++++++++++
 tb/tb_conv2d_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution: raster pixels in, one bias+ReLU result per fully populated window.
// Pipeline: accept edge -> S1 window capture -> S2 products -> S3 sum/ReLU register.
module conv2d_stream #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5,
    parameter int BIT_WIDTH = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int RELU_EN   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [IN_WIDTH-1:0]            pixel,
    input  logic [(K*K+1)*BIT_WIDTH-1:0]   kernel,
    output logic                           out_valid,
    output logic [OUT_WIDTH-1:0]           result,
    output logic                           frame_done
);
    localparam int KK     = K * K;
    localparam int CW     = $clog2(IMG_W + 1);
    localparam int RW     = $clog2(IMG_H + 1);
    localparam int SR_LEN = (K - 1) * IMG_W + K;
    localparam int PW     = IN_WIDTH + BIT_WIDTH + 1;
    localparam int KW     = (KK + 1) * BIT_WIDTH;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  col_end, row_end, win_ok, frame_end;
    logic                  acc_v, s1_v, s2_v;
    logic                  acc_last, s1_last, s2_last;
    logic [IN_WIDTH-1:0]   sreg [SR_LEN];
    logic [IN_WIDTH-1:0]   win [KK];
    logic [KW-1:0]         kern_q, kern_s1;
    logic signed [PW-1:0]  prod [KK];
    logic [BIT_WIDTH-1:0]  bias_s2;
    logic [OUT_WIDTH-1:0]  sum, sum_relu;

    assign col_end   = (col == CW'(IMG_W - 1));
    assign row_end   = (row == RW'(IMG_H - 1));
    assign win_ok    = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    assign frame_end = row_end && col_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            acc_v      <= 1'b0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            acc_last   <= 1'b0;
            s1_last    <= 1'b0;
            s2_last    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            result     <= '0;
        end else begin
            if (in_valid) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            acc_v      <= in_valid && win_ok;
            acc_last   <= in_valid && win_ok && frame_end;
            s1_v       <= acc_v;
            s1_last    <= acc_last;
            s2_v       <= s1_v;
            s2_last    <= s1_last;
            out_valid  <= s2_v;
            frame_done <= s2_last;
            if (s2_v) begin
                result <= sum_relu;
            end
        end
    end

    // Datapath is not reset; the valid chain above keeps stale contents from being emitted.
    // The kernel copy travels with the window so a new frame's latch cannot corrupt the
    // last windows of the previous frame still in flight.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            sreg[0] <= pixel;
            for (int i = 1; i < SR_LEN; i++) begin
                sreg[i] <= sreg[i-1];
            end
            if (row == '0 && col == '0) begin
                kern_q <= kernel;
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win[r*K+c] <= sreg[(K-1-r)*IMG_W + (K-1-c)];
            end
        end
        kern_s1 <= kern_q;
        for (int i = 0; i < KK; i++) begin
            prod[i] <= PW'($signed({1'b0, win[i]})) *
                       PW'($signed(kern_s1[i*BIT_WIDTH +: BIT_WIDTH]));
        end
        bias_s2 <= kern_s1[KK*BIT_WIDTH +: BIT_WIDTH];
    end

    always_comb begin
        sum = {{(OUT_WIDTH-BIT_WIDTH){bias_s2[BIT_WIDTH-1]}}, bias_s2};
        for (int i = 0; i < KK; i++) begin
            sum = sum + {{(OUT_WIDTH-PW){prod[i][PW-1]}}, prod[i]};
        end
        sum_relu = ((RELU_EN != 0) && sum[OUT_WIDTH-1]) ? '0 : sum;
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream at default geometry (32x32 frame, 5x5 kernel).
// Two instances share inputs: dut_a clamps negatives, dut_b passes the signed sum.
module tb_conv2d_stream;
    localparam int W    = 32;
    localparam int K    = 5;
    localparam int KW   = (K*K+1)*8;
    localparam int OWN  = W - K + 1;
    localparam int NOUT = 784;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    pixel = 8'd0;
    logic [KW-1:0] kernel;
    logic          ov_a, fd_a, ov_b, fd_b;
    logic [31:0]   res_a, res_b;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int fd_stray = 0;
    logic [31:0] res_q[$];
    logic [31:0] resb_q[$];
    bit          fd_q[$];
    int          st_q[$];
    int          exp_st_q[$];
    logic [KW-1:0] kern_ones, kern_center, kern_neg;

    conv2d_stream #(.RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pixel(pixel), .kernel(kernel),
        .out_valid(ov_a), .result(res_a), .frame_done(fd_a)
    );

    conv2d_stream #(.RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pixel(pixel), .kernel(kernel),
        .out_valid(ov_b), .result(res_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov_a) begin
            res_q.push_back(res_a);
            fd_q.push_back(fd_a);
            st_q.push_back(cyc);
        end
        if (fd_a && !ov_a) fd_stray++;
        if (ov_b) resb_q.push_back(res_b);
    end

    task automatic drive(input logic v, input logic [7:0] p);
        @(negedge clk);
        in_valid = v;
        pixel    = p;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic clear_q();
        res_q.delete(); resb_q.delete(); fd_q.delete();
        st_q.delete(); exp_st_q.delete();
        fd_stray = 0;
    endtask

    // mode 0: pixel=1, mode 1: pixel=col, mode 2: pixel=10
    task automatic send_pixels(input int start, input int count, input int mode, input bit bubbles);
        for (int n = start; n < start + count; n++) begin
            int pos;
            int r;
            int c;
            logic [7:0] p;
            pos = n % (W*W);
            r = pos / W;
            c = pos % W;
            if (bubbles) begin
                while ($urandom_range(0, 1) == 1) drive(1'b0, 8'hAA);
            end
            p = (mode == 0) ? 8'd1 : (mode == 1) ? 8'(c) : 8'd10;
            drive(1'b1, p);
            // accepted at edge cyc+1, result visible after edge cyc+4
            if (r >= K-1 && c >= K-1) exp_st_q.push_back(cyc + 4);
        end
    endtask

    function automatic logic [31:0] exp_val(input int mode, input int j);
        int oc;
        oc = j % OWN;
        case (mode)
            0:       return 32'd25;
            1:       return 32'(oc + 5);
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        kernel = kern_ones;
        idle(4);
        vectors++; if (ov_a !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", ov_a); end
        vectors++; if (res_a !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", res_a); end
        vectors++; if (fd_a !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", fd_a); end
        vectors++; if (ov_b !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid_b: got %b expected 0", ov_b); end
        vectors++; if (res_b !== 32'd0) begin miscompares++; $display("FAIL reset_result_b: got %h expected 0", res_b); end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        clear_q();
    endtask

    task automatic test_ones();
        int nerr = 0;
        int fdn = 0;
        int fdpos = -1;
        kernel = kern_ones;
        clear_q();
        send_pixels(0, W*W, 0, 1'b0);
        idle(6);
        vectors++; if (res_q.size() !== NOUT) begin miscompares++; $display("FAIL ones_count: got %0d expected %0d", res_q.size(), NOUT); end
        for (int j = 0; j < res_q.size(); j++) begin
            vectors++;
            if (res_q[j] !== 32'd25) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL ones_value[%0d]: got %0d expected 25", j, res_q[j]);
            end
            if (fd_q[j]) begin fdn++; fdpos = j; end
        end
        vectors++; if (fdn !== 1 || fdpos !== NOUT-1) begin miscompares++; $display("FAIL ones_frame_done: got %0d pulses at %0d expected 1 at %0d", fdn, fdpos, NOUT-1); end
        vectors++; if (fd_stray !== 0) begin miscompares++; $display("FAIL ones_fd_stray: got %0d expected 0", fd_stray); end
    endtask

    task automatic test_center();
        int nerr = 0;
        kernel = kern_center;
        clear_q();
        send_pixels(0, W*W, 1, 1'b0);
        idle(6);
        vectors++; if (res_q.size() !== NOUT) begin miscompares++; $display("FAIL center_count: got %0d expected %0d", res_q.size(), NOUT); end
        for (int j = 0; j < res_q.size(); j++) begin
            vectors++;
            if (res_q[j] !== exp_val(1, j)) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL center_value[%0d]: got %0d expected %0d", j, res_q[j], exp_val(1, j));
            end
        end
        vectors++; if (fd_q.size() > 0 && fd_q[fd_q.size()-1] !== 1'b1) begin miscompares++; $display("FAIL center_frame_done: got 0 expected 1 on last output"); end
    endtask

    task automatic test_neg_relu();
        int nerr = 0;
        kernel = kern_neg;
        clear_q();
        send_pixels(0, W*W, 2, 1'b0);
        idle(6);
        vectors++; if (res_q.size() !== NOUT) begin miscompares++; $display("FAIL neg_count_a: got %0d expected %0d", res_q.size(), NOUT); end
        vectors++; if (resb_q.size() !== NOUT) begin miscompares++; $display("FAIL neg_count_b: got %0d expected %0d", resb_q.size(), NOUT); end
        for (int j = 0; j < res_q.size(); j++) begin
            vectors++;
            if (res_q[j] !== 32'd0) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL neg_relu[%0d]: got %h expected 00000000", j, res_q[j]);
            end
        end
        for (int j = 0; j < resb_q.size(); j++) begin
            vectors++;
            if (resb_q[j] !== 32'hFFFFFF06) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL neg_signed[%0d]: got %h expected ffffff06", j, resb_q[j]);
            end
        end
    endtask

    task automatic test_bubbles();
        int nerr = 0;
        kernel = kern_center;
        clear_q();
        send_pixels(0, W*W, 1, 1'b1);
        idle(6);
        vectors++; if (res_q.size() !== NOUT) begin miscompares++; $display("FAIL bubble_count: got %0d expected %0d", res_q.size(), NOUT); end
        for (int j = 0; j < res_q.size() && j < exp_st_q.size(); j++) begin
            vectors++;
            if (res_q[j] !== exp_val(1, j) || st_q[j] !== exp_st_q[j]) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL bubble_out[%0d]: got %0d at cycle %0d expected %0d at cycle %0d",
                                        j, res_q[j], st_q[j], exp_val(1, j), exp_st_q[j]);
            end
        end
        vectors++; if (fd_q.size() > 0 && fd_q[fd_q.size()-1] !== 1'b1) begin miscompares++; $display("FAIL bubble_frame_done: got 0 expected 1 on last output"); end
    endtask

    task automatic test_reset_midframe();
        int nerr = 0;
        kernel = kern_center;
        clear_q();
        send_pixels(0, 500, 1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if (ov_a !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", ov_a); end
        vectors++; if (res_a !== 32'd0) begin miscompares++; $display("FAIL midrst_result: got %h expected 0", res_a); end
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        send_pixels(0, W*W, 1, 1'b0);
        idle(6);
        vectors++; if (res_q.size() !== NOUT) begin miscompares++; $display("FAIL midrst_count: got %0d expected %0d", res_q.size(), NOUT); end
        for (int j = 0; j < res_q.size() && j < exp_st_q.size(); j++) begin
            vectors++;
            if (res_q[j] !== exp_val(1, j) || st_q[j] !== exp_st_q[j]) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL midrst_out[%0d]: got %0d at cycle %0d expected %0d at cycle %0d",
                                        j, res_q[j], st_q[j], exp_val(1, j), exp_st_q[j]);
            end
        end
    endtask

    task automatic test_kernel_switch();
        int nerr = 0;
        int fdn = 0;
        logic [31:0] e;
        kernel = kern_ones;
        clear_q();
        send_pixels(0, 500, 0, 1'b0);
        kernel = kern_center;
        send_pixels(500, W*W - 500, 0, 1'b0);
        send_pixels(W*W, W*W, 1, 1'b0);
        idle(6);
        vectors++; if (res_q.size() !== 2*NOUT) begin miscompares++; $display("FAIL kswitch_count: got %0d expected %0d", res_q.size(), 2*NOUT); end
        for (int j = 0; j < res_q.size(); j++) begin
            e = (j < NOUT) ? exp_val(0, j) : exp_val(1, j - NOUT);
            vectors++;
            if (res_q[j] !== e) begin
                miscompares++; nerr++;
                if (nerr <= 8) $display("FAIL kswitch_value[%0d]: got %0d expected %0d", j, res_q[j], e);
            end
            if (fd_q[j] && (j == NOUT-1 || j == 2*NOUT-1)) fdn++;
            else if (fd_q[j]) fdn += 100;
        end
        vectors++; if (fdn !== 2) begin miscompares++; $display("FAIL kswitch_frame_done: got score %0d expected 2", fdn); end
    endtask

    initial begin
        kern_ones   = '0;
        kern_center = '0;
        kern_neg    = '0;
        for (int i = 0; i < K*K; i++) begin
            kern_ones[i*8 +: 8] = 8'd1;
            kern_neg[i*8 +: 8]  = 8'hFF;
        end
        kern_center[12*8 +: 8]  = 8'd1;
        kern_center[K*K*8 +: 8] = 8'd3;

        test_reset();
        test_ones();
        test_center();
        test_neg_relu();
        test_bubbles();
        test_reset_midframe();
        test_kernel_switch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
